// File: rtl/ccis_c0_rd_arbiter_if.sv
// CCI-S channel 0 types and the bundled port interface for the c0 read arbiter.

package ccis_c0_rd_arbiter_pkg;

  localparam int unsigned MDATA_W = 13;
  localparam int unsigned DATA_W  = 512;

  // Memory request header driven on c0Tx
  typedef struct packed {
    logic [5:0]         rsvd1;
    logic [3:0]         req_type;
    logic [5:0]         rsvd0;
    logic [31:0]        addr;
    logic [MDATA_W-1:0] mdata;
  } t_ccis_ReqMemHdr;

  // Response header received on c0Rx
  typedef struct packed {
    logic [3:0]         resp_type;
    logic               rsvd;
    logic [MDATA_W-1:0] mdata;
  } t_ccis_RspMemHdr;

  typedef struct packed {
    t_ccis_ReqMemHdr hdr;
    logic            rdValid;
  } t_if_ccis_c0_Tx;

  typedef struct packed {
    t_ccis_RspMemHdr    hdr;
    logic [DATA_W-1:0]  data;
    logic               wrValid;
    logic               rdValid;
    logic               cfgValid;
    logic               umsgValid;
    logic               intrValid;
  } t_if_ccis_c0_Rx;

  // Idle channel 0 request: no valids, header zeroed
  function automatic t_if_ccis_c0_Tx ccis_c0Tx_clearValids();
    t_if_ccis_c0_Tx r;
    r = '0;
    return r;
  endfunction

endpackage

// master = the arbiter; slave = the AFU read engines plus CCI-S side.
interface ccis_c0_rd_arbiter_if
  import ccis_c0_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 32
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  t_if_ccis_c0_Tx                        c0Tx;
  logic                                  c0TxAlmFull;
  t_if_ccis_c0_Rx                        c0Rx;
  logic [NUM_PORTS-1:0]                  req_valid;
  t_ccis_ReqMemHdr [NUM_PORTS-1:0]       req_hdr;
  logic [NUM_PORTS-1:0]                  req_ready;
  logic [NUM_PORTS-1:0]                  rsp_valid;
  logic [12-IDX_W:0]                     rsp_mdata;
  logic [DATA_W-1:0]                     rsp_data;
  logic [NUM_PORTS-1:0][CNT_W-1:0]       outstanding;
  logic [1:0]                            err_sticky;

  modport master (
    output c0Tx, req_ready, rsp_valid, rsp_mdata, rsp_data, outstanding, err_sticky,
    input  c0TxAlmFull, c0Rx, req_valid, req_hdr
  );

  modport slave (
    input  c0Tx, req_ready, rsp_valid, rsp_mdata, rsp_data, outstanding, err_sticky,
    output c0TxAlmFull, c0Rx, req_valid, req_hdr
  );

endinterface

// File: rtl/ccis_c0_rd_arbiter.sv
// Round-robin arbiter sharing the CCI-S c0 read-request path between NUM_PORTS
// requesters; tags mdata with the port index and routes read responses back.

module ccis_c0_rd_arbiter
  import ccis_c0_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 32,
  parameter int unsigned IDX_W           = $clog2(NUM_PORTS),
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  ccis_c0_rd_arbiter_if.master bus
);

  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned MD_W  = 13 - IDX_W;

  // Registered state
  logic                             active_q;
  logic                             alm_full_q;
  logic [IDX_W-1:0]                 ptr_q;
  logic [IDX_W-1:0]                 ptr_nxt;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt_q;
  logic [NUM_PORTS-1:0][CNT_W-1:0]  cnt_nxt;
  logic [1:0]                       err_q;
  logic [1:0]                       err_nxt;
  t_if_ccis_c0_Tx                   c0tx_q;
  t_if_ccis_c0_Tx                   c0tx_nxt;
  logic [NUM_PORTS-1:0]             rsp_valid_q;
  logic [NUM_PORTS-1:0]             rsp_valid_nxt;
  logic [MD_W-1:0]                  rsp_mdata_q;
  logic [MD_W-1:0]                  rsp_mdata_nxt;
  logic [DATA_W-1:0]                rsp_data_q;
  logic [DATA_W-1:0]                rsp_data_nxt;

  // Combinational decode
  logic [NUM_PORTS-1:0]             eligible_c;
  logic [NUM_PORTS-1:0]             grant_c;
  logic [NUM_PORTS-1:0]             route_c;
  logic                             grant_any_c;
  logic [IDX_W-1:0]                 grant_idx_c;
  logic                             rsp_rd_c;
  logic [IDX_W-1:0]                 rsp_tag_c;

  // A port may be granted only with headroom and no registered almost-full;
  // active_q keeps grants off while reset is (or was just) asserted.
  always_comb begin
    eligible_c = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible_c[i] = active_q && !alm_full_q && bus.req_valid[i] &&
                      (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin search: first eligible port at or after the pointer, wrapping.
  always_comb begin
    logic [PTR_W-1:0] cand;
    grant_any_c = 1'b0;
    grant_idx_c = '0;
    cand        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + PTR_W'(k);
      if (cand >= PTR_W'(NUM_PORTS)) begin
        cand = cand - PTR_W'(NUM_PORTS);
      end
      if (!grant_any_c && eligible_c[cand[IDX_W-1:0]]) begin
        grant_any_c = 1'b1;
        grant_idx_c = cand[IDX_W-1:0];
      end
    end
  end

  // One-hot grant and one-hot response route (unroutable tags match no port).
  always_comb begin
    grant_c   = '0;
    route_c   = '0;
    rsp_rd_c  = bus.c0Rx.rdValid;
    rsp_tag_c = bus.c0Rx.hdr.mdata[IDX_W-1:0];
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant_c[i] = grant_any_c && (grant_idx_c == IDX_W'(i));
      route_c[i] = rsp_rd_c && (rsp_tag_c == IDX_W'(i));
    end
  end

  // Build the issued header: rsvd cleared, port index packed into low mdata bits.
  always_comb begin
    t_ccis_ReqMemHdr sel;
    sel              = bus.req_hdr[grant_idx_c];
    c0tx_nxt         = c0tx_q;
    c0tx_nxt.rdValid = 1'b0;
    if (grant_any_c) begin
      c0tx_nxt.rdValid      = 1'b1;
      c0tx_nxt.hdr          = '0;
      c0tx_nxt.hdr.req_type = sel.req_type;
      c0tx_nxt.hdr.addr     = sel.addr;
      c0tx_nxt.hdr.mdata    = {sel.mdata[MD_W-1:0], grant_idx_c};
    end
  end

  // Capture the read response; data/mdata hold between responses.
  always_comb begin
    rsp_valid_nxt = route_c;
    rsp_mdata_nxt = rsp_mdata_q;
    rsp_data_nxt  = rsp_data_q;
    if (rsp_rd_c) begin
      rsp_mdata_nxt = bus.c0Rx.hdr.mdata[12:IDX_W];
      rsp_data_nxt  = bus.c0Rx.data;
    end
  end

  // Outstanding counters, sticky errors and round-robin pointer update.
  always_comb begin
    cnt_nxt = cnt_q;
    err_nxt = err_q;
    ptr_nxt = ptr_q;
    if (rsp_rd_c && !(|route_c)) begin
      err_nxt[0] = 1'b1;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      case ({grant_c[i], route_c[i]})
        2'b10: cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
        2'b01: begin
          if (cnt_q[i] == '0) begin
            err_nxt[1] = 1'b1;
          end else begin
            cnt_nxt[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: cnt_nxt[i] = cnt_q[i];
      endcase
    end
    if (grant_any_c) begin
      ptr_nxt = (grant_idx_c == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    end
  end

  // State registers; reset abandons in-flight reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q    <= 1'b0;
      alm_full_q  <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      err_q       <= '0;
      c0tx_q      <= ccis_c0Tx_clearValids();
      rsp_valid_q <= '0;
      rsp_mdata_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      active_q    <= 1'b1;
      alm_full_q  <= bus.c0TxAlmFull;
      ptr_q       <= ptr_nxt;
      cnt_q       <= cnt_nxt;
      err_q       <= err_nxt;
      c0tx_q      <= c0tx_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_mdata_q <= rsp_mdata_nxt;
      rsp_data_q  <= rsp_data_nxt;
    end
  end

  assign bus.req_ready   = grant_c;
  assign bus.c0Tx        = c0tx_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_mdata   = rsp_mdata_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.outstanding = cnt_q;
  assign bus.err_sticky  = err_q;

  // Non-read c0Rx valids, response type and request rsvd bits are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{bus.c0Rx, bus.req_hdr};

endmodule

// File: tb/tb_ccis_c0_rd_arbiter.sv
// Directed bench for ccis_c0_rd_arbiter: three instances cover the 2-port
// default, a 2-deep outstanding limit and a 3-port unroutable-tag case.

module tb_ccis_c0_rd_arbiter;
  import ccis_c0_rd_arbiter_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  t_ccis_ReqMemHdr h;
  t_ccis_ReqMemHdr exp_hdr;

  ccis_c0_rd_arbiter_if #(.NUM_PORTS(2), .MAX_OUTSTANDING(32)) ifa ();
  ccis_c0_rd_arbiter_if #(.NUM_PORTS(2), .MAX_OUTSTANDING(2))  ifb ();
  ccis_c0_rd_arbiter_if #(.NUM_PORTS(3), .MAX_OUTSTANDING(32)) ifc ();

  ccis_c0_rd_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(32)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  ccis_c0_rd_arbiter #(.NUM_PORTS(2), .MAX_OUTSTANDING(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );
  ccis_c0_rd_arbiter #(.NUM_PORTS(3), .MAX_OUTSTANDING(32)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    ifa.c0TxAlmFull = 1'b0; ifa.c0Rx = '0; ifa.req_hdr = '0; ifa.req_valid = 2'b11;
    ifb.c0TxAlmFull = 1'b0; ifb.c0Rx = '0; ifb.req_hdr = '0; ifb.req_valid = '0;
    ifc.c0TxAlmFull = 1'b0; ifc.c0Rx = '0; ifc.req_hdr = '0; ifc.req_valid = '0;

    // Reset state, with requests pending
    repeat (2) step();
    #1;
    check("rst_req_ready",   64'(ifa.req_ready), 64'(0));
    check("rst_rdvalid",     64'(ifa.c0Tx.rdValid), 64'(0));
    check("rst_outstanding", 64'(ifa.outstanding), 64'(0));
    check("rst_err",         64'(ifa.err_sticky), 64'(0));
    check("rst_rsp_valid",   64'(ifa.rsp_valid), 64'(0));
    ifa.req_valid = '0;
    reset_n = 1'b1;
    step();

    // Both ports request for 6 cycles: grants alternate, issue one cycle later
    h = '1; h.req_type = 4'h4; h.addr = 32'h0000_1000; h.mdata = 13'h0010;
    ifa.req_hdr[0] = h;
    h.addr = 32'h0000_2000; h.mdata = 13'h0021;
    ifa.req_hdr[1] = h;
    ifa.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("alt_grant", 64'(ifa.req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k == 0) begin
        check("alt_issue_first", 64'(ifa.c0Tx.rdValid), 64'(0));
      end else begin
        check("alt_issue", 64'(ifa.c0Tx.rdValid), 64'(1));
        check("alt_tag", 64'(ifa.c0Tx.hdr.mdata[0]), 64'((k - 1) % 2));
      end
      step();
    end
    #1;
    check("alt_issue_last", 64'(ifa.c0Tx.rdValid), 64'(1));
    exp_hdr = '0; exp_hdr.req_type = 4'h4; exp_hdr.addr = 32'h0000_2000; exp_hdr.mdata = 13'h0043;
    check("alt_hdr", 64'(ifa.c0Tx.hdr), 64'(exp_hdr));
    ifa.req_valid = '0;
    #1;
    check("alt_idle_grant", 64'(ifa.req_ready), 64'(0));
    step();
    check("alt_idle_issue", 64'(ifa.c0Tx.rdValid), 64'(0));
    check("alt_cnt0", 64'(ifa.outstanding[0]), 64'(3));
    check("alt_cnt1", 64'(ifa.outstanding[1]), 64'(3));

    // Drain with routed responses alternating between ports
    for (int k = 0; k < 6; k++) begin
      ifa.c0Rx.rdValid   = 1'b1;
      ifa.c0Rx.hdr.mdata = 13'((k << 4) | (k & 1));
      ifa.c0Rx.data      = 512'(64'hD000_0000_0000_0000 | 64'(k));
      step();
      check("drain_valid", 64'(ifa.rsp_valid), ((k & 1) != 0) ? 64'h2 : 64'h1);
      check("drain_mdata", 64'(ifa.rsp_mdata), 64'(k << 3));
      check("drain_data",  ifa.rsp_data[63:0], 64'hD000_0000_0000_0000 | 64'(k));
    end
    ifa.c0Rx = '0;
    check("drain_cnt", 64'(ifa.outstanding), 64'(0));
    check("drain_err", 64'(ifa.err_sticky), 64'(0));

    // Port 1 alone with mdata 0x0ABC, then its response
    h = '0; h.req_type = 4'h4; h.addr = 32'h0000_ABCD; h.mdata = 13'h0ABC;
    ifa.req_hdr[1] = h;
    ifa.req_valid = 2'b10;
    #1;
    check("p1_grant", 64'(ifa.req_ready), 64'h2);
    step();
    ifa.req_valid      = '0;
    ifa.c0Rx.rdValid   = 1'b1;
    ifa.c0Rx.hdr.mdata = 13'h1579;
    ifa.c0Rx.data      = 512'(64'h0123_4567_89AB_CDEF);
    #1;
    check("p1_issue", 64'(ifa.c0Tx.rdValid), 64'(1));
    check("p1_mdata", 64'(ifa.c0Tx.hdr.mdata), 64'h1579);
    check("p1_cnt_up", 64'(ifa.outstanding[1]), 64'(1));
    step();
    ifa.c0Rx = '0;
    check("p1_rsp_valid", 64'(ifa.rsp_valid), 64'h2);
    check("p1_rsp_mdata", 64'(ifa.rsp_mdata), 64'hABC);
    check("p1_rsp_data",  ifa.rsp_data[63:0], 64'h0123_4567_89AB_CDEF);
    check("p1_cnt_down",  64'(ifa.outstanding[1]), 64'(0));

    // Almost-full rises while both request: one slack grant, then none
    ifa.req_valid   = 2'b11;
    ifa.c0TxAlmFull = 1'b1;
    #1;
    check("af_slack_grant", 64'(ifa.req_ready), 64'h1);
    step();
    check("af_blocked", 64'(ifa.req_ready), 64'(0));
    check("af_slack_issue", 64'(ifa.c0Tx.rdValid), 64'(1));
    for (int j = 0; j < 3; j++) begin
      step();
      check("af_hold_grant", 64'(ifa.req_ready), 64'(0));
      check("af_hold_issue", 64'(ifa.c0Tx.rdValid), 64'(0));
    end
    ifa.c0TxAlmFull = 1'b0;
    #1;
    check("af_fall_same_cycle", 64'(ifa.req_ready), 64'(0));
    step();
    check("af_resume", 64'(ifa.req_ready), 64'h2);
    step();
    ifa.req_valid = '0;
    check("af_resume_issue", 64'(ifa.c0Tx.rdValid), 64'(1));
    check("af_resume_tag", 64'(ifa.c0Tx.hdr.mdata[0]), 64'(1));

    // Grant and response to port 0 in the same cycle: count unchanged
    ifa.req_valid      = 2'b01;
    ifa.c0Rx.rdValid   = 1'b1;
    ifa.c0Rx.hdr.mdata = 13'h0000;
    #1;
    check("same_grant", 64'(ifa.req_ready), 64'h1);
    step();
    ifa.req_valid = '0;
    ifa.c0Rx      = '0;
    check("same_cnt", 64'(ifa.outstanding[0]), 64'(1));
    check("same_rsp", 64'(ifa.rsp_valid), 64'h1);

    // Drain both ports, then underflow port 0
    ifa.c0Rx.rdValid = 1'b1; ifa.c0Rx.hdr.mdata = 13'h0000;
    step();
    ifa.c0Rx.hdr.mdata = 13'h0001;
    step();
    check("uf_pre_cnt", 64'(ifa.outstanding), 64'(0));
    check("uf_pre_err", 64'(ifa.err_sticky), 64'(0));
    ifa.c0Rx.hdr.mdata = 13'h0000;
    step();
    ifa.c0Rx = '0;
    check("uf_err", 64'(ifa.err_sticky), 64'h2);
    check("uf_cnt", 64'(ifa.outstanding[0]), 64'(0));

    // Outstanding limit of 2 on port 0
    ifb.req_valid = 2'b01;
    #1;
    check("lim_grant1", 64'(ifb.req_ready), 64'h1);
    step();
    check("lim_grant2", 64'(ifb.req_ready), 64'h1);
    step();
    check("lim_block", 64'(ifb.req_ready), 64'(0));
    check("lim_cnt", 64'(ifb.outstanding[0]), 64'(2));
    step();
    check("lim_block_hold", 64'(ifb.req_ready), 64'(0));
    ifb.req_valid = 2'b11;
    #1;
    check("lim_other_port", 64'(ifb.req_ready), 64'h2);
    step();
    ifb.req_valid = 2'b01;
    #1;
    check("lim_block_again", 64'(ifb.req_ready), 64'(0));
    check("lim_cnt_hold", 64'(ifb.outstanding[0]), 64'(2));
    ifb.c0Rx.rdValid   = 1'b1;
    ifb.c0Rx.hdr.mdata = 13'h0000;
    step();
    ifb.c0Rx = '0;
    #1;
    check("lim_freed_cnt", 64'(ifb.outstanding[0]), 64'(1));
    check("lim_freed_grant", 64'(ifb.req_ready), 64'h1);
    step();
    check("lim_refill", 64'(ifb.req_ready), 64'(0));
    check("lim_refill_cnt", 64'(ifb.outstanding[0]), 64'(2));
    step();
    check("lim_refill_hold", 64'(ifb.req_ready), 64'(0));
    ifb.req_valid = '0;

    // Three ports: tag 3 is unroutable, tag 2 routes (and underflows)
    ifc.c0Rx.rdValid   = 1'b1;
    ifc.c0Rx.hdr.mdata = 13'h0003;
    step();
    ifc.c0Rx = '0;
    check("tag3_rsp", 64'(ifc.rsp_valid), 64'(0));
    check("tag3_err", 64'(ifc.err_sticky), 64'h1);
    ifc.c0Rx.rdValid   = 1'b1;
    ifc.c0Rx.hdr.mdata = 13'h0016;
    step();
    ifc.c0Rx = '0;
    check("tag2_rsp", 64'(ifc.rsp_valid), 64'h4);
    check("tag2_mdata", 64'(ifc.rsp_mdata), 64'h5);
    check("tag2_err", 64'(ifc.err_sticky), 64'h3);

    // Reset mid-burst: outputs clear immediately, pointer back to port 0
    ifa.req_valid = 2'b11;
    #1;
    check("burst_g0", 64'(ifa.req_ready), 64'h2);
    step();
    check("burst_g1", 64'(ifa.req_ready), 64'h1);
    step();
    check("burst_g2", 64'(ifa.req_ready), 64'h2);
    reset_n = 1'b0;
    #1;
    check("arst_req_ready", 64'(ifa.req_ready), 64'(0));
    check("arst_c0tx",      64'(ifa.c0Tx), 64'(0));
    check("arst_cnt",       64'(ifa.outstanding), 64'(0));
    check("arst_err",       64'(ifa.err_sticky), 64'(0));
    check("arst_rsp_valid", 64'(ifa.rsp_valid), 64'(0));
    check("arst_rsp_mdata", 64'(ifa.rsp_mdata), 64'(0));
    check("arst_rsp_data",  ifa.rsp_data[63:0], 64'(0));
    step();
    reset_n = 1'b1;
    #1;
    check("arst_release_idle", 64'(ifa.req_ready), 64'(0));
    step();
    check("arst_ptr", 64'(ifa.req_ready), 64'h1);
    ifa.req_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
